// File: rtl/lfsr_pkg.sv
// Shared definitions for the 20-bit LFSR pattern generator and checker.
// Stage i of the shift register sits on bus bit WIDTH-1-i, so bus bit 0 is the last stage.
package lfsr_pkg;

    localparam int unsigned LFSR_WIDTH   = 20;
    localparam int unsigned LFSR_TAP_POS = 3;
    localparam int unsigned LFSR_ERR_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        TRACK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One LFSR step on the bus view: the last stage feeds the first and the tap stage.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] c);
        logic [LFSR_WIDTH-1:0] n;
        n = {c[0], c[LFSR_WIDTH-1:1]};
        n[LFSR_WIDTH-1-LFSR_TAP_POS] = c[LFSR_WIDTH-LFSR_TAP_POS] ^ c[0];
        return n;
    endfunction

endpackage

// File: rtl/lfsr_seq_checker.sv
// Receive-side LFSR checker: seeds from the first word, predicts each next word,
// counts mismatches and measures the period until the seed recurs.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH   = LFSR_WIDTH,
    parameter int unsigned TAP_POS = LFSR_TAP_POS,
    parameter int unsigned ERR_W   = LFSR_ERR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             locked,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] period,
    output logic             done,
    output logic             pass,
    output logic             zero_seed
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] n;
        n = {c[0], c[WIDTH-1:1]};
        n[WIDTH-1-TAP_POS] = c[WIDTH-TAP_POS] ^ c[0];
        return n;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             locked_q, locked_d;
    logic             mismatch_q, mismatch_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             zero_q, zero_d;

    logic word_ok;
    logic recur;
    logic at_max;

    assign word_ok = (in_data == exp_q);
    assign recur   = word_ok && (in_data == seed_q);
    assign at_max  = (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = SEED;
        end else if (in_valid) begin
            unique case (state_q)
                SEED:    state_d = (in_data == '0) ? DONE : TRACK;
                TRACK:   if (recur || at_max) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // A corrupted word still counts and becomes the basis of the next prediction.
    always_comb begin
        seed_d     = seed_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        err_d      = err_q;
        locked_d   = locked_q;
        mismatch_d = 1'b0;
        done_d     = done_q;
        pass_d     = pass_q;
        zero_d     = zero_q;
        if (start) begin
            period_d = '0;
            err_d    = '0;
            locked_d = 1'b0;
            done_d   = 1'b0;
            pass_d   = 1'b0;
            zero_d   = 1'b0;
        end else if (in_valid) begin
            unique case (state_q)
                SEED: begin
                    seed_d = in_data;
                    exp_d  = nxt(in_data);
                    cnt_d  = WIDTH'(1);
                    if (in_data == '0) begin
                        zero_d = 1'b1;
                        done_d = 1'b1;
                        pass_d = 1'b0;
                    end else begin
                        locked_d = 1'b1;
                    end
                end
                TRACK: begin
                    exp_d = nxt(in_data);
                    if (recur) begin
                        period_d = cnt_q;
                        done_d   = 1'b1;
                        locked_d = 1'b0;
                        pass_d   = (err_q == '0) && at_max;
                    end else begin
                        if (!word_ok) begin
                            mismatch_d = 1'b1;
                            if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                        end
                        if (at_max) begin
                            period_d = '0;
                            done_d   = 1'b1;
                            pass_d   = 1'b0;
                            locked_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seed_q     <= '0;
            exp_q      <= '0;
            cnt_q      <= '0;
            period_q   <= '0;
            err_q      <= '0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            seed_q     <= seed_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
            mismatch_q <= mismatch_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            zero_q     <= zero_d;
        end
    end

    assign locked    = locked_q;
    assign mismatch  = mismatch_q;
    assign err_count = err_q;
    assign period    = period_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign zero_seed = zero_q;

endmodule
